// File: rtl/stall_pattern_pkg.sv
// rtl/stall_pattern_pkg.sv - shared types and constants for the stall pattern scheduler
package stall_pattern_pkg;

  typedef enum logic [1:0] {
    STATIC_LOW  = 2'd0,
    STATIC_HIGH = 2'd1,
    FIXED       = 2'd2,
    RANDOM      = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOW    = 2'd1,
    HIGH   = 2'd2,
    STATIC = 2'd3
  } fsm_state_t;

  localparam logic [2:0] ADDR_MODE     = 3'd0;
  localparam logic [2:0] ADDR_LOW_MIN  = 3'd1;
  localparam logic [2:0] ADDR_LOW_MAX  = 3'd2;
  localparam logic [2:0] ADDR_HIGH_MIN = 3'd3;
  localparam logic [2:0] ADDR_HIGH_MAX = 3'd4;
  localparam logic [2:0] ADDR_RUN_LEN  = 3'd5;

  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr_galois.sv
// rtl/lfsr_galois.sv - right-shifting Galois LFSR that steps only when asked
//   i_clk      clock
//   i_a_rst_n  asynchronous active-low reset, loads SEED
//   i_adv      advance one step this cycle
//   o_value    current LFSR contents
module lfsr_galois #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter logic [WIDTH-1:0] TAPS  = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic             i_clk,
  input  logic             i_a_rst_n,
  input  logic             i_adv,
  output logic [WIDTH-1:0] o_value
);

  // An all-zero seed locks the register at zero forever.
  if (SEED == '0) begin : g_seed_check
    $error("lfsr_galois: SEED must be non-zero");
  end

  logic [WIDTH-1:0] value_q;

  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      value_q <= SEED;
    end else if (i_adv) begin
      value_q <= (value_q >> 1) ^ (value_q[0] ? TAPS : '0);
    end
  end

  assign o_value = value_q;

endmodule

// File: rtl/stall_pattern_scheduler.sv
// rtl/stall_pattern_scheduler.sv - register-configured LOW/HIGH stall pattern sequencer
//   i_clk, i_a_rst_n             clock, asynchronous active-low reset
//   i_cfg_we/addr/data           register write port, accepted only while idle
//   i_start, i_stop              run control; stop wins over start
//   o_state                      generated pattern
//   o_busy, o_done               sequencer active, one-cycle completion pulse
//   o_cfg_err                    sticky refused-start flag, cleared by any accepted write
//   o_period_cnt                 completed LOW+HIGH periods
module stall_pattern_scheduler
  import stall_pattern_pkg::*;
#(
  parameter int          CNT_WIDTH = 8,
  parameter int          RUN_WIDTH = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 i_clk,
  input  logic                 i_a_rst_n,
  input  logic                 i_cfg_we,
  input  logic [2:0]           i_cfg_addr,
  input  logic [RUN_WIDTH-1:0] i_cfg_data,
  input  logic                 i_start,
  input  logic                 i_stop,
  output logic                 o_state,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_cfg_err,
  output logic [RUN_WIDTH-1:0] o_period_cnt
);

  localparam int SPAN_W = CNT_WIDTH + 1;

  mode_t                mode_q;
  logic [CNT_WIDTH-1:0] low_min_q, low_max_q, high_min_q, high_max_q;
  logic [RUN_WIDTH-1:0] run_len_q, period_cnt_q;
  fsm_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] phase_cnt_q, limit_q;
  logic                 done_q, cfg_err_q;
  logic                 draw, finish, refuse;
  logic                 cfg_wr, cfg_bad, is_static, phase_end, last_period;
  logic [15:0]          lfsr_value;
  logic [CNT_WIDTH-1:0] lfsr_low, draw_min, draw_max, draw_len;
  logic [SPAN_W-1:0]    span, rand_off;

  lfsr_galois #(
    .WIDTH (16),
    .SEED  (LFSR_SEED),
    .TAPS  (LFSR_TAPS)
  ) u_lfsr (
    .i_clk     (i_clk),
    .i_a_rst_n (i_a_rst_n),
    .i_adv     (draw),
    .o_value   (lfsr_value)
  );

  assign cfg_wr      = i_cfg_we && (state_q == IDLE) && (i_cfg_addr <= ADDR_RUN_LEN);
  assign is_static   = (mode_q == STATIC_LOW) || (mode_q == STATIC_HIGH);
  assign phase_end   = (phase_cnt_q == limit_q);
  assign last_period = (run_len_q != '0) && ((period_cnt_q + RUN_WIDTH'(1)) == run_len_q);
  assign lfsr_low    = CNT_WIDTH'(lfsr_value);

  always_comb begin
    cfg_bad = (low_min_q == '0) || (high_min_q == '0);
    if (mode_q == RANDOM) begin
      cfg_bad = cfg_bad || (low_min_q > low_max_q) || (high_min_q > high_max_q);
    end
  end

  // Length of the phase being entered: only leaving LOW enters HIGH.
  always_comb begin
    draw_min = (state_q == LOW) ? high_min_q : low_min_q;
    draw_max = (state_q == LOW) ? high_max_q : low_max_q;
    span     = {1'b0, draw_max} - {1'b0, draw_min} + SPAN_W'(1);
    if (span == '0) begin
      span = SPAN_W'(1);
    end
    rand_off = {1'b0, lfsr_low} % span;
    draw_len = draw_min;
    if (mode_q == RANDOM) begin
      draw_len = draw_min + CNT_WIDTH'(rand_off);
    end
  end

  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      mode_q     <= FIXED;
      low_min_q  <= CNT_WIDTH'(1);
      low_max_q  <= CNT_WIDTH'(1);
      high_min_q <= CNT_WIDTH'(1);
      high_max_q <= CNT_WIDTH'(1);
      run_len_q  <= RUN_WIDTH'(1);
    end else if (cfg_wr) begin
      case (i_cfg_addr)
        ADDR_MODE:     mode_q     <= mode_t'(i_cfg_data[1:0]);
        ADDR_LOW_MIN:  low_min_q  <= CNT_WIDTH'(i_cfg_data);
        ADDR_LOW_MAX:  low_max_q  <= CNT_WIDTH'(i_cfg_data);
        ADDR_HIGH_MIN: high_min_q <= CNT_WIDTH'(i_cfg_data);
        ADDR_HIGH_MAX: high_max_q <= CNT_WIDTH'(i_cfg_data);
        ADDR_RUN_LEN:  run_len_q  <= i_cfg_data;
        default:       ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    draw    = 1'b0;
    finish  = 1'b0;
    refuse  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start && !i_stop) begin
          if (is_static) begin
            state_d = STATIC;
          end else if (cfg_bad) begin
            refuse = 1'b1;
          end else begin
            state_d = LOW;
            draw    = 1'b1;
          end
        end
      end
      LOW: begin
        if (i_stop) begin
          state_d = IDLE;
        end else if (phase_end) begin
          state_d = HIGH;
          draw    = 1'b1;
        end
      end
      HIGH: begin
        if (i_stop) begin
          state_d = IDLE;
        end else if (phase_end) begin
          if (last_period) begin
            state_d = IDLE;
            finish  = 1'b1;
          end else begin
            state_d = LOW;
            draw    = 1'b1;
          end
        end
      end
      STATIC: begin
        if (i_stop) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      phase_cnt_q  <= '0;
      limit_q      <= '0;
      period_cnt_q <= '0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      done_q <= finish;
      // phase_cnt runs 1..limit so the last cycle of a phase is phase_cnt == limit.
      if (draw) begin
        limit_q     <= draw_len;
        phase_cnt_q <= CNT_WIDTH'(1);
      end else if ((state_q == LOW) || (state_q == HIGH)) begin
        phase_cnt_q <= phase_cnt_q + CNT_WIDTH'(1);
      end
      if ((state_q == IDLE) && (state_d != IDLE)) begin
        period_cnt_q <= '0;
      end else if ((state_q == HIGH) && !i_stop && phase_end) begin
        period_cnt_q <= period_cnt_q + RUN_WIDTH'(1);
      end
      if (refuse) begin
        cfg_err_q <= 1'b1;
      end else if (cfg_wr) begin
        cfg_err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    o_busy       = (state_q != IDLE);
    o_state      = (state_q == HIGH) || ((state_q == STATIC) && (mode_q == STATIC_HIGH));
    o_done       = done_q;
    o_cfg_err    = cfg_err_q;
    o_period_cnt = period_cnt_q;
  end

endmodule

// File: tb/tb_stall_pattern_scheduler.sv
// tb/tb_stall_pattern_scheduler.sv - self-checking bench for stall_pattern_scheduler
module tb_stall_pattern_scheduler;

  localparam int CW = 8;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [RW-1:0] cfg_data = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          o_state, o_busy, o_done, o_cfg_err;
  logic [RW-1:0] o_period_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stall_pattern_scheduler #(
    .CNT_WIDTH (CW),
    .RUN_WIDTH (RW),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .i_clk        (clk),
    .i_a_rst_n    (rst_n),
    .i_cfg_we     (cfg_we),
    .i_cfg_addr   (cfg_addr),
    .i_cfg_data   (cfg_data),
    .i_start      (start),
    .i_stop       (stop),
    .o_state      (o_state),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_cfg_err    (o_cfg_err),
    .o_period_cnt (o_period_cnt)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A run is expanded up front into the list of per-cycle outputs it must produce.
  typedef struct {
    logic        st;
    int          pcnt;
    logic [15:0] lf;
  } ent_t;

  ent_t        q[$];
  int          m_mode = 2, m_lmin = 1, m_lmax = 1, m_hmin = 1, m_hmax = 1, m_run = 1;
  logic [15:0] m_lfsr = 16'hACE1;
  logic        m_err = 1'b0;
  logic        e_state = 1'b0, e_busy = 1'b0, e_done = 1'b0, static_on = 1'b0;
  int          e_pcnt = 0;
  logic [15:0] e_lfsr = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    int          ex[4] = '{16, 14, 13, 11};
    logic [15:0] m = '0;
    foreach (ex[i]) m[ex[i]-1] = 1'b1;
    return v[0] ? ((v >> 1) ^ m) : (v >> 1);
  endfunction

  function automatic int phase_len(input int mn, input int mx, input logic [15:0] v);
    if (m_mode == 3) return mn + (int'(v[7:0]) % (mx - mn + 1));
    return mn;
  endfunction

  task automatic build_trace();
    logic [15:0] lf;
    int          p, len;
    ent_t        e;
    lf = m_lfsr;
    p  = 0;
    q.delete();
    while ((m_run != 0 && p < m_run) || (m_run == 0 && q.size() < 2000)) begin
      len = phase_len(m_lmin, m_lmax, lf);
      lf  = lfsr_step(lf);
      e.st = 1'b0; e.pcnt = p; e.lf = lf;
      repeat (len) q.push_back(e);
      len = phase_len(m_hmin, m_hmax, lf);
      lf  = lfsr_step(lf);
      e.st = 1'b1; e.pcnt = p; e.lf = lf;
      repeat (len) q.push_back(e);
      p++;
    end
  endtask

  task automatic pop_entry();
    ent_t e;
    e = q.pop_front();
    e_state = e.st; e_pcnt = e.pcnt; e_lfsr = e.lf; e_busy = 1'b1; e_done = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_mode = 2; m_lmin = 1; m_lmax = 1; m_hmin = 1; m_hmax = 1; m_run = 1;
    m_lfsr = 16'hACE1; e_lfsr = 16'hACE1; m_err = 1'b0;
    e_state = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_pcnt = 0; static_on = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else if (e_busy) begin
      if (stop) begin
        q.delete(); static_on = 1'b0;
        e_busy = 1'b0; e_state = 1'b0; e_done = 1'b0; m_lfsr = e_lfsr;
      end else if (!static_on) begin
        if (q.size() != 0) pop_entry();
        else begin
          e_busy = 1'b0; e_state = 1'b0; e_done = 1'b1; e_pcnt = m_run; m_lfsr = e_lfsr;
        end
      end
    end else begin
      e_done = 1'b0;
      if (cfg_we && cfg_addr <= 3'd5) begin
        case (cfg_addr)
          3'd0: m_mode = int'(cfg_data[1:0]);
          3'd1: m_lmin = int'(cfg_data[7:0]);
          3'd2: m_lmax = int'(cfg_data[7:0]);
          3'd3: m_hmin = int'(cfg_data[7:0]);
          3'd4: m_hmax = int'(cfg_data[7:0]);
          default: m_run = int'(cfg_data);
        endcase
        m_err = 1'b0;
      end
      if (start && !stop) begin
        if (m_mode < 2) begin
          static_on = 1'b1; e_busy = 1'b1; e_state = (m_mode == 1); e_pcnt = 0; e_lfsr = m_lfsr;
        end else if (m_lmin == 0 || m_hmin == 0 ||
                     (m_mode == 3 && (m_lmin > m_lmax || m_hmin > m_hmax))) begin
          m_err = 1'b1;
        end else begin
          build_trace();
          pop_entry();
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic chk_bounds = 1'b0;
  logic pb = 1'b0, ps = 1'b0;
  int   run_len_seen = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("state", 32'(o_state), 32'(e_state));
      check("busy", 32'(o_busy), 32'(e_busy));
      check("done", 32'(o_done), 32'(e_done));
      check("cfg_err", 32'(o_cfg_err), 32'(m_err));
      check("period_cnt", 32'(o_period_cnt), 32'(e_pcnt) & 32'hFFFF);
      if (chk_bounds) begin
        if (pb && (!o_busy || o_state != ps)) begin
          n_cmp++;
          if (ps ? (run_len_seen < 1 || run_len_seen > 4) : (run_len_seen < 2 || run_len_seen > 5)) begin
            n_bad++;
            $display("FAIL phase_len: got %0d for level %0d outside bounds at %0t", run_len_seen, ps, $time);
          end
        end
        if (o_busy) run_len_seen = (pb && o_state == ps) ? run_len_seen + 1 : 1;
        else run_len_seen = 0;
        pb = o_busy;
        ps = o_state;
      end else begin
        pb = 1'b0;
        run_len_seen = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input int d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = RW'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int t1_st[11] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
  int t2_st[7]  = '{0, 0, 0, 1, 0, 0, 1};
  int n;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(o_state), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_cfg_err", 32'(o_cfg_err), 0);
    check("rst_period_cnt", 32'(o_period_cnt), 0);
    rst_n = 1'b1;
    tick();

    // FIXED 3/2, two periods
    wr(3'd0, 2); wr(3'd1, 3); wr(3'd3, 2); wr(3'd5, 2);
    go();
    for (int c = 0; c < 11; c++) begin
      check("t1_state", 32'(o_state), 32'(t1_st[c]));
      check("t1_busy", 32'(o_busy), (c < 10) ? 1 : 0);
      check("t1_done", 32'(o_done), (c == 10) ? 1 : 0);
      if (c < 10) tick();
    end
    check("t1_period_cnt", 32'(o_period_cnt), 2);
    tick();

    // RANDOM from the reset seed
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    wr(3'd0, 3); wr(3'd1, 2); wr(3'd2, 5); wr(3'd3, 1); wr(3'd4, 4); wr(3'd5, 50);
    chk_bounds = 1'b1;
    go();
    for (int c = 0; c < 7; c++) begin
      check("t2_state_lit", 32'(o_state), 32'(t2_st[c]));
      tick();
    end
    n = 0;
    while (!o_done && n < 1000) begin
      tick();
      n++;
    end
    check("t2_done_seen", 32'(o_done), 1);
    check("t2_period_cnt", 32'(o_period_cnt), 50);
    tick();
    chk_bounds = 1'b0;

    // config error, then recovery
    wr(3'd1, 6); wr(3'd2, 4);
    go();
    check("t3_cfg_err_set", 32'(o_cfg_err), 1);
    check("t3_not_busy", 32'(o_busy), 0);
    tick();
    check("t3_still_idle", 32'(o_busy), 0);
    wr(3'd2, 8);
    check("t3_cfg_err_clr", 32'(o_cfg_err), 0);
    go();
    check("t3_runs", 32'(o_busy), 1);
    repeat (5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t3_stop_busy", 32'(o_busy), 0);
    check("t3_stop_done", 32'(o_done), 0);
    tick();

    // STATIC_HIGH, start+stop collision, then stop
    wr(3'd0, 1);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("t4_stop_wins", 32'(o_busy), 0);
    go();
    for (int i = 0; i < 100; i++) begin
      check("t4_static_high", 32'(o_state), 1);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4_stop_state", 32'(o_state), 0);
    check("t4_stop_busy", 32'(o_busy), 0);
    check("t4_stop_done", 32'(o_done), 0);
    tick();
    check("t4_no_done", 32'(o_done), 0);

    // FIXED 1/1 endless, ignored write and start while busy
    wr(3'd0, 2); wr(3'd1, 1); wr(3'd3, 1); wr(3'd5, 0);
    go();
    for (int c = 1; c <= 20; c++) begin
      check("t5_toggle", 32'(o_state), (c % 2 == 0) ? 1 : 0);
      check("t5_period_cnt", 32'(o_period_cnt), 32'((c - 1) / 2));
      if (c == 6) begin
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = RW'(5); start = 1'b1;
      end
      tick();
      cfg_we = 1'b0; start = 1'b0;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t5_stop_busy", 32'(o_busy), 0);
    tick();

    // async reset mid-HIGH, then defaults
    wr(3'd1, 3); wr(3'd3, 2); wr(3'd5, 2);
    go();
    repeat (3) tick();
    check("t6_in_high", 32'(o_state), 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_state", 32'(o_state), 0);
    check("t6_async_busy", 32'(o_busy), 0);
    check("t6_async_done", 32'(o_done), 0);
    check("t6_async_cfg_err", 32'(o_cfg_err), 0);
    check("t6_async_period", 32'(o_period_cnt), 0);
    #1 rst_n = 1'b1;
    tick();
    go();
    check("t6_c1_state", 32'(o_state), 0);
    check("t6_c1_busy", 32'(o_busy), 1);
    tick();
    check("t6_c2_state", 32'(o_state), 1);
    tick();
    check("t6_c3_done", 32'(o_done), 1);
    check("t6_c3_busy", 32'(o_busy), 0);
    check("t6_c3_period", 32'(o_period_cnt), 1);
    tick();
    check("t6_c4_done", 32'(o_done), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
